// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle sequencer (master) and the MIPS datapath (slave).
// The datapath returns the opcode and the memory handshake; the sequencer drives the enables.
interface multicycle_control_fsm_if;
    logic [5:0] op;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic [3:0] state;
    logic       instr_done;
    logic       illegal_op;
    logic       bus_error;

    modport master (
        input  op, mem_ready,
        output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, state, instr_done, illegal_op, bus_error
    );

    modport slave (
        output op, mem_ready,
        input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, state, instr_done, illegal_op, bus_error
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS control sequencer: FETCH/DECODE/EXECUTE/MEM/WB with memory-ready waits,
// illegal-opcode detection and a per-state memory timeout that parks the FSM in ERROR.
module multicycle_control_fsm #(
    parameter bit MEM_WAIT_EN = 1'b1,
    parameter int TIMEOUT     = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    multicycle_control_fsm_if.master  bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_RTYPE_EX = 4'd6,
        S_ALU_WB   = 4'd7,
        S_BEQ      = 4'd8,
        S_ADDI_EX  = 4'd9,
        S_ADDI_WB  = 4'd10,
        S_JUMP     = 4'd11,
        S_ERROR    = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam bit         TO_EN   = (TIMEOUT != 0);
    localparam logic [7:0] TO_LAST = TO_EN ? 8'(TIMEOUT - 1) : 8'd0;

    state_t     state_q;
    state_t     mem_done_next;
    logic [7:0] wait_cnt;
    logic       rdy;
    logic       op_legal;
    logic       timeout_hit;

    assign rdy         = bus.mem_ready || !MEM_WAIT_EN;
    assign timeout_hit = TO_EN && (wait_cnt == TO_LAST);
    assign op_legal    = (bus.op == OP_RTYPE) || (bus.op == OP_LW) || (bus.op == OP_SW) ||
                         (bus.op == OP_ADDI)  || (bus.op == OP_BEQ) || (bus.op == OP_J);

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case can infer a latch.
        mem_done_next = S_FETCH;
        case (state_q)
            S_FETCH: mem_done_next = S_DECODE;
            S_MEMRD: mem_done_next = S_MEMWB;
            default: mem_done_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state_q  <= S_FETCH;
            wait_cnt <= 8'd0;
        end else begin
            case (state_q)
                S_FETCH, S_MEMRD, S_MEMWR: begin
                    // A ready in the last allowed cycle beats the timeout.
                    if (rdy) begin
                        wait_cnt <= 8'd0;
                        state_q  <= mem_done_next;
                    end else if (timeout_hit) begin
                        wait_cnt <= 8'd0;
                        state_q  <= S_ERROR;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_DECODE: begin
                    case (bus.op)
                        OP_RTYPE:      state_q <= S_RTYPE_EX;
                        OP_LW, OP_SW:  state_q <= S_MEMADR;
                        OP_ADDI:       state_q <= S_ADDI_EX;
                        OP_BEQ:        state_q <= S_BEQ;
                        OP_J:          state_q <= S_JUMP;
                        default:       state_q <= S_FETCH;
                    endcase
                end
                S_MEMADR:   state_q <= (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
                S_RTYPE_EX: state_q <= S_ALU_WB;
                S_ADDI_EX:  state_q <= S_ADDI_WB;
                S_MEMWB, S_ALU_WB, S_ADDI_WB, S_BEQ, S_JUMP: state_q <= S_FETCH;
                S_ERROR:    state_q <= S_ERROR;
                default:    state_q <= S_ERROR;
            endcase
        end
    end

    always_comb begin
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.iord          = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'b00;
        bus.alu_op        = 2'b00;
        bus.pc_source     = 2'b00;
        bus.instr_done    = 1'b0;
        bus.illegal_op    = 1'b0;
        bus.bus_error     = 1'b0;
        bus.state         = state_q;

        if (reset) begin
            bus.state = 4'd0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    bus.mem_read  = 1'b1;
                    bus.alu_src_b = 2'b01;
                    bus.ir_write  = rdy;
                    bus.pc_write  = rdy;
                end
                S_DECODE: begin
                    bus.alu_src_b  = 2'b11;
                    bus.illegal_op = !op_legal;
                end
                S_MEMADR, S_ADDI_EX: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = 2'b10;
                end
                S_MEMRD: begin
                    bus.mem_read = 1'b1;
                    bus.iord     = 1'b1;
                end
                S_MEMWB: begin
                    bus.reg_write  = 1'b1;
                    bus.mem_to_reg = 1'b1;
                    bus.instr_done = 1'b1;
                end
                S_MEMWR: begin
                    bus.mem_write  = 1'b1;
                    bus.iord       = 1'b1;
                    bus.instr_done = rdy;
                end
                S_RTYPE_EX: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_op    = 2'b10;
                end
                S_ALU_WB: begin
                    bus.reg_write  = 1'b1;
                    bus.reg_dst    = 1'b1;
                    bus.instr_done = 1'b1;
                end
                S_ADDI_WB: begin
                    bus.reg_write  = 1'b1;
                    bus.instr_done = 1'b1;
                end
                S_BEQ: begin
                    bus.alu_src_a     = 1'b1;
                    bus.alu_op        = 2'b01;
                    bus.pc_write_cond = 1'b1;
                    bus.pc_source     = 2'b01;
                    bus.instr_done    = 1'b1;
                end
                S_JUMP: begin
                    bus.pc_write   = 1'b1;
                    bus.pc_source  = 2'b10;
                    bus.instr_done = 1'b1;
                end
                S_ERROR:  bus.bus_error = 1'b1;
                default:  bus.bus_error = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: a per-cycle vector table of inputs and
// hand-written expected outputs, plus timeout and no-wait-parameter sequences.
module tb_multicycle_control_fsm;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        rdy;
        logic [3:0]  st;
        logic [19:0] out;
    } vec_t;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] ADDI = 6'b001000, BEQ = 6'b000100, JMP = 6'b000010, BAD = 6'b111111;

    // Expected-output bit weights: {pc_write ... bus_error, spare 0}.
    localparam logic [19:0] PW = 20'h80000, PWC = 20'h40000, IORD = 20'h20000, MR = 20'h10000;
    localparam logic [19:0] MW = 20'h08000, IRW = 20'h04000, RDST = 20'h02000, M2R = 20'h01000;
    localparam logic [19:0] RW = 20'h00800, SRCA = 20'h00400, SRCB_01 = 20'h00100;
    localparam logic [19:0] SRCB_10 = 20'h00200, SRCB_11 = 20'h00300, ALUOP_01 = 20'h00040;
    localparam logic [19:0] ALUOP_10 = 20'h00080, PCS_01 = 20'h00010, PCS_10 = 20'h00020;
    localparam logic [19:0] DONE = 20'h00008, ILL = 20'h00004, BERR = 20'h00002;
    localparam logic [19:0] FR = MR | IRW | PW | SRCB_01;
    localparam logic [19:0] FW = MR | SRCB_01;
    localparam logic [19:0] BEQ_O = SRCA | ALUOP_01 | PWC | PCS_01 | DONE;
    localparam logic [19:0] J_O = PW | PCS_10 | DONE;

    logic clk = 1'b0;
    logic reset;
    logic reset2;
    int   checks = 0;
    int   errors = 0;
    logic [19:0] out1, out2;

    always #5 clk = ~clk;

    multicycle_control_fsm_if bus ();
    multicycle_control_fsm_if bus2 ();

    multicycle_control_fsm #(.MEM_WAIT_EN(1'b1), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    multicycle_control_fsm #(.MEM_WAIT_EN(1'b0), .TIMEOUT(0)) dut_nowait (
        .clk(clk), .reset(reset2), .bus(bus2)
    );

    assign out1 = {bus.pc_write, bus.pc_write_cond, bus.iord, bus.mem_read, bus.mem_write,
                   bus.ir_write, bus.reg_dst, bus.mem_to_reg, bus.reg_write, bus.alu_src_a,
                   bus.alu_src_b, bus.alu_op, bus.pc_source, bus.instr_done, bus.illegal_op,
                   bus.bus_error, 1'b0};
    assign out2 = {bus2.pc_write, bus2.pc_write_cond, bus2.iord, bus2.mem_read, bus2.mem_write,
                   bus2.ir_write, bus2.reg_dst, bus2.mem_to_reg, bus2.reg_write, bus2.alu_src_a,
                   bus2.alu_src_b, bus2.alu_op, bus2.pc_source, bus2.instr_done, bus2.illegal_op,
                   bus2.bus_error, 1'b0};

    function automatic vec_t mk(input logic r, input logic [5:0] o, input logic m,
                                input logic [3:0] s, input logic [19:0] e);
        vec_t v;
        v.rst = r; v.op = o; v.rdy = m; v.st = s; v.out = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, compare at the falling edge, then let the rising edge act.
    task automatic run_vec(input vec_t v, input string tag);
        reset         = v.rst;
        bus.op        = v.op;
        bus.mem_ready = v.rdy;
        @(negedge clk);
        check({tag, ".state"}, {16'd0, bus.state}, {16'd0, v.st});
        check({tag, ".outs"}, out1, v.out);
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[43];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset2         = 1'b1;
        bus2.op        = LW;
        bus2.mem_ready = 1'b0;

        vecs[0]  = mk(1, LW, 1, 0, 20'h0);
        vecs[1]  = mk(0, LW, 1, 0, FR);
        vecs[2]  = mk(0, LW, 1, 1, SRCB_11);
        vecs[3]  = mk(0, LW, 1, 2, SRCA | SRCB_10);
        vecs[4]  = mk(0, LW, 1, 3, MR | IORD);
        vecs[5]  = mk(0, LW, 1, 4, RW | M2R | DONE);
        vecs[6]  = mk(0, RT, 1, 0, FR);
        vecs[7]  = mk(0, RT, 1, 1, SRCB_11);
        vecs[8]  = mk(0, RT, 1, 6, SRCA | ALUOP_10);
        vecs[9]  = mk(0, RT, 1, 7, RW | RDST | DONE);
        vecs[10] = mk(0, ADDI, 1, 0, FR);
        vecs[11] = mk(0, ADDI, 1, 1, SRCB_11);
        vecs[12] = mk(0, ADDI, 1, 9, SRCA | SRCB_10);
        vecs[13] = mk(0, ADDI, 1, 10, RW | DONE);
        vecs[14] = mk(0, BEQ, 1, 0, FR);
        vecs[15] = mk(0, BEQ, 1, 1, SRCB_11);
        vecs[16] = mk(0, BEQ, 1, 8, BEQ_O);
        vecs[17] = mk(0, JMP, 1, 0, FR);
        vecs[18] = mk(0, JMP, 1, 1, SRCB_11);
        vecs[19] = mk(0, JMP, 1, 11, J_O);
        vecs[20] = mk(0, SW, 1, 0, FR);
        vecs[21] = mk(0, SW, 1, 1, SRCB_11);
        vecs[22] = mk(0, SW, 1, 2, SRCA | SRCB_10);
        vecs[23] = mk(0, SW, 0, 5, MW | IORD);
        vecs[24] = mk(0, SW, 0, 5, MW | IORD);
        vecs[25] = mk(0, SW, 0, 5, MW | IORD);
        vecs[26] = mk(0, SW, 1, 5, MW | IORD | DONE);
        vecs[27] = mk(0, BAD, 1, 0, FR);
        vecs[28] = mk(0, BAD, 1, 1, SRCB_11 | ILL);
        vecs[29] = mk(0, JMP, 0, 0, FW);
        vecs[30] = mk(0, JMP, 1, 0, FR);
        vecs[31] = mk(0, JMP, 1, 1, SRCB_11);
        vecs[32] = mk(0, JMP, 1, 11, J_O);
        vecs[33] = mk(0, LW, 1, 0, FR);
        vecs[34] = mk(0, LW, 1, 1, SRCB_11);
        vecs[35] = mk(0, LW, 1, 2, SRCA | SRCB_10);
        vecs[36] = mk(0, LW, 0, 3, MR | IORD);
        vecs[37] = mk(1, LW, 0, 0, 20'h0);
        vecs[38] = mk(0, ADDI, 1, 0, FR);
        vecs[39] = mk(0, ADDI, 1, 1, SRCB_11);
        vecs[40] = mk(0, ADDI, 1, 9, SRCA | SRCB_10);
        vecs[41] = mk(0, ADDI, 1, 10, RW | DONE);
        vecs[42] = mk(0, ADDI, 0, 0, FW);

        for (int i = 0; i < 43; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Fetch stalls for the whole timeout window: ERROR, sticky until reset.
        run_vec(mk(1, LW, 0, 0, 20'h0), "to_rst");
        for (int i = 0; i < 16; i++) run_vec(mk(0, LW, 0, 0, FW), $sformatf("to_wait%0d", i));
        for (int i = 0; i < 3; i++) run_vec(mk(0, LW, 1, 12, BERR), $sformatf("to_err%0d", i));

        // Ready in the 16th cycle wins over the timeout.
        run_vec(mk(1, BEQ, 0, 0, 20'h0), "rdy_rst");
        for (int i = 0; i < 15; i++) run_vec(mk(0, BEQ, 0, 0, FW), $sformatf("rdy_wait%0d", i));
        run_vec(mk(0, BEQ, 1, 0, FR), "rdy_last");
        run_vec(mk(0, BEQ, 1, 1, SRCB_11), "rdy_decode");
        run_vec(mk(0, BEQ, 1, 8, BEQ_O), "rdy_beq");

        // The wait counter restarts from zero on the next fetch.
        for (int i = 0; i < 15; i++) run_vec(mk(0, BEQ, 0, 0, FW), $sformatf("clr_wait%0d", i));
        run_vec(mk(0, BEQ, 1, 0, FR), "clr_last");
        run_vec(mk(0, BEQ, 1, 1, SRCB_11), "clr_decode");

        // With memory waits disabled, a stuck-low mem_ready still lets lw run at zero wait.
        reset = 1'b1;
        @(negedge clk);
        check("nw.reset", {out2[19:1], 1'b0} | {16'd0, bus2.state}, 20'h0);
        @(posedge clk);
        #1;
        reset2 = 1'b0;
        begin
            logic [3:0]  nw_st[6];
            logic [19:0] nw_out[6];
            nw_st[0] = 4'd0; nw_out[0] = FR;
            nw_st[1] = 4'd1; nw_out[1] = SRCB_11;
            nw_st[2] = 4'd2; nw_out[2] = SRCA | SRCB_10;
            nw_st[3] = 4'd3; nw_out[3] = MR | IORD;
            nw_st[4] = 4'd4; nw_out[4] = RW | M2R | DONE;
            nw_st[5] = 4'd0; nw_out[5] = FR;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                check($sformatf("nw%0d.state", i), {16'd0, bus2.state}, {16'd0, nw_st[i]});
                check($sformatf("nw%0d.outs", i), out2, nw_out[i]);
                @(posedge clk);
                #1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
